perf_counter_bank: RTL and testbench
====================================

PERF_COUNTER_BANK -- requirements
Module: perf_counter_bank

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent event channels (1..16).
REQ-002 Parameter CNT_W, default 32, width of every channel counter, cycle counter and snapshot register (8..64).
REQ-003 Parameter SNAP_INTERVAL, default 1000, enabled cycles between automatic snapshots (2..2^CNT_W-1).
REQ-004 Clk  input  1  single clock; all state updates on rising edge.
REQ-005 Rst  input  1  asynchronous, active-low reset.
REQ-006 En  input  1  global count enable.
REQ-007 Freeze  input  1  holds all counters and the interval counter while high.
REQ-008 Clear  input  1  synchronous clear of counters, interval counter and overflow flags.
REQ-009 Event  input  NUM_CH  per-channel increment request, one count per cycle per bit.
REQ-010 RdSel  input  max(1,clog2(NUM_CH))  channel select for readback.
REQ-011 RdLive  output  CNT_W  registered live count of channel RdSel.
REQ-012 RdSnap  output  CNT_W  registered snapshot of channel RdSel.
REQ-013 CycleCount  output  CNT_W  enabled-cycle counter.
REQ-014 SnapValid  output  1  one-cycle pulse when a new snapshot set is loaded.
REQ-015 Overflow  output  NUM_CH  sticky per-channel overflow flag.

Function
REQ-016 State machine SHALL have states IDLE, COUNT, HOLD; IDLE when En=0, COUNT when En=1 and Freeze=0, HOLD when En=1 and Freeze=1; state is registered and applies on the cycle after the input change.
REQ-017 In COUNT, CycleCount SHALL increment by 1 per cycle and channel i SHALL increment by 1 each cycle Event[i]=1; in IDLE and HOLD nothing increments and events are dropped.
REQ-018 A counter at all-ones that increments SHALL wrap to 0 and set Overflow[i] (CycleCount wraps without a flag).
REQ-019 Interval counter SHALL count COUNT-state cycles 0..SNAP_INTERVAL-1 and wrap; on the cycle it equals SNAP_INTERVAL-1, every snapshot register SHALL load the value its channel counter takes at that same edge (post-increment).
REQ-020 SnapValid SHALL assert for exactly one cycle, on the cycle following the snapshot load edge.
REQ-021 Clear SHALL take priority over every other update in the same cycle: counters, CycleCount, interval counter and Overflow go to 0, events that cycle are lost, no snapshot occurs; snapshot registers are retained.
REQ-022 Clear SHALL act in any state, including IDLE and HOLD.
REQ-023 RdLive and RdSnap SHALL have one-cycle latency from RdSel; RdSel beyond NUM_CH-1 SHALL return 0.
REQ-024 Simultaneous snapshot and readback of the same channel SHALL return the pre-load snapshot on RdSnap that cycle and the new value one cycle later.

Reset
REQ-025 Rst low SHALL immediately force state IDLE, all counters, snapshots, interval counter, RdLive, RdSnap, CycleCount, SnapValid and Overflow to 0.
REQ-026 Rst asserted mid-interval SHALL discard the partial interval; after release, the first snapshot occurs after a full SNAP_INTERVAL COUNT cycles.

Configuration
REQ-027 Macro PERF_SATURATE_EN defined: channel counters SHALL saturate at all-ones instead of wrapping; Overflow still sets on the first attempted increment past all-ones.
REQ-028 Macro PERF_SATURATE_EN undefined: wrap behaviour of REQ-018 applies.

Structure
REQ-029 Package perf_pkg SHALL hold the state enum (IDLE, COUNT, HOLD) and the default parameter constants.
REQ-030 One sub-module perf_event_counter SHALL implement a single channel (counter, overflow flag, saturate option), instantiated NUM_CH times via generate.

Verification
REQ-031 NUM_CH=4, SNAP_INTERVAL=10, En=1, Event=4'b0101 every cycle for 10 cycles -> SnapValid pulses once on cycle 11; RdSnap ch0=10, ch1=0, ch2=10.
REQ-032 Counting, Freeze=1 for 5 cycles with Event=4'b1111 -> no counter or CycleCount change; counting resumes the cycle after Freeze drops.
REQ-033 CNT_W=8, ch3 preset to 255 by 255 events, one more event -> RdLive ch3=0, Overflow[3]=1 (with PERF_SATURATE_EN: RdLive=255, Overflow[3]=1).
REQ-034 Clear and Event=4'b1111 in same cycle at interval count 9 -> all counts 0, no SnapValid, snapshot registers unchanged.
REQ-035 Rst pulsed low asynchronously mid-interval at count 6 -> all outputs 0 immediately; next SnapValid exactly 10 COUNT cycles after release.
REQ-036 RdSel=5 with NUM_CH=4 -> RdLive=0 and RdSnap=0 one cycle later.

Source files
------------

// File: rtl/perf_pkg.sv
// perf_pkg: shared FSM state type and default parameters for the perf counter bank
package perf_pkg;
  typedef enum logic [1:0] {IDLE, COUNT, HOLD} state_e;
  localparam int NUM_CH_DEF = 4;
  localparam int CNT_W_DEF = 32;
  localparam longint unsigned SNAP_INTERVAL_DEF = 1000;
endpackage

// File: rtl/perf_event_counter.sv
// perf_event_counter: one event channel (counter + sticky overflow); PERF_SATURATE_EN selects saturation instead of wrap
module perf_event_counter #(
  parameter int CNT_W = 32
)(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt,
  output logic [CNT_W-1:0] o_nxt,
  output logic             o_ovf
);
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_next;
  logic             r_ovf;
  logic             w_max;
  assign w_max = &r_cnt;
`ifdef PERF_SATURATE_EN
  assign w_next = w_max ? r_cnt : r_cnt + CNT_W'(1);
`else
  assign w_next = r_cnt + CNT_W'(1);
`endif
  // o_nxt is the value the counter holds after this edge, used for snapshots
  assign o_nxt = i_inc ? w_next : r_cnt;
  assign o_cnt = r_cnt;
  assign o_ovf = r_ovf;
  // counter and sticky overflow; clear wins over increment
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (i_clear) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (i_inc) begin
      r_cnt <= w_next;
      r_ovf <= r_ovf | w_max;
    end
  end
endmodule

// File: rtl/perf_counter_bank.sv
// perf_counter_bank: bank of event counters with cycle counter and periodic snapshots; PERF_SATURATE_EN makes channels saturate
module perf_counter_bank import perf_pkg::*; #(
  parameter int              NUM_CH        = NUM_CH_DEF,
  parameter int              CNT_W         = CNT_W_DEF,
  parameter longint unsigned SNAP_INTERVAL = SNAP_INTERVAL_DEF,
  localparam int             SEL_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
)(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_freeze,
  input  logic              i_clear,
  input  logic [NUM_CH-1:0] i_event,
  input  logic [SEL_W-1:0]  i_rd_sel,
  output logic [CNT_W-1:0]  o_rd_live,
  output logic [CNT_W-1:0]  o_rd_snap,
  output logic [CNT_W-1:0]  o_cycle_count,
  output logic              o_snap_valid,
  output logic [NUM_CH-1:0] o_overflow
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SNAP_INTERVAL - 1);
  state_e           r_state, w_next_state;
  logic [CNT_W-1:0] r_intv, r_cycle, r_rd_live, r_rd_snap;
  logic [CNT_W-1:0] w_cnt [NUM_CH];
  logic [CNT_W-1:0] w_nxt [NUM_CH];
  logic [CNT_W-1:0] r_snap [NUM_CH];
  logic             r_snap_valid, w_inc, w_snap, w_sel_ok;
  // next state follows the enable/freeze inputs, taking effect one cycle later
  always_comb begin
    w_next_state = !i_en ? IDLE : (i_freeze ? HOLD : COUNT);
  end
  // state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else r_state <= w_next_state;
  end
  assign w_inc    = (r_state == COUNT) && !i_clear;
  assign w_snap   = w_inc && (r_intv == LAST);
  assign w_sel_ok = {1'b0, i_rd_sel} < (SEL_W + 1)'(NUM_CH);
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    perf_event_counter #(.CNT_W(CNT_W)) u_ch (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_clear (i_clear),
      .i_inc   (w_inc && i_event[g]),
      .o_cnt   (w_cnt[g]),
      .o_nxt   (w_nxt[g]),
      .o_ovf   (o_overflow[g])
    );
  end
  // cycle counter, interval counter and the snapshot-valid pulse
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cycle      <= '0;
      r_intv       <= '0;
      r_snap_valid <= 1'b0;
    end else begin
      r_snap_valid <= w_snap;
      if (i_clear) begin
        r_cycle <= '0;
        r_intv  <= '0;
      end else if (w_inc) begin
        r_cycle <= r_cycle + CNT_W'(1);
        r_intv  <= w_snap ? '0 : r_intv + CNT_W'(1);
      end
    end
  end
  // snapshot registers capture post-increment counts; clear leaves them alone
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_CH; i++) r_snap[i] <= '0;
    end else if (w_snap) begin
      for (int i = 0; i < NUM_CH; i++) r_snap[i] <= w_nxt[i];
    end
  end
  // registered readback of the pre-update values; unmapped selects read zero
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_live <= '0;
      r_rd_snap <= '0;
    end else begin
      r_rd_live <= w_sel_ok ? w_cnt[i_rd_sel] : '0;
      r_rd_snap <= w_sel_ok ? r_snap[i_rd_sel] : '0;
    end
  end
  assign o_rd_live     = r_rd_live;
  assign o_rd_snap     = r_rd_snap;
  assign o_cycle_count = r_cycle;
  assign o_snap_valid  = r_snap_valid;
endmodule

// File: tb/tb_perf_counter_bank.sv
// tb_perf_counter_bank: randomized and directed checks of perf_counter_bank against a behavioural model
module tb_perf_counter_bank;
  localparam int N = 4, N2 = 3, W = 8, SI = 10, MAXV = 255;
`ifdef PERF_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, fr = 1'b0, clr = 1'b0;
  logic [N-1:0] ev = '0;
  logic [1:0] sel = '0, sel2 = '0;
  logic [W-1:0] live, snap, cyc, live2, snap2, cyc2;
  logic sv, sv2;
  logic [N-1:0] ovf;
  logic [N2-1:0] ovf2;
  int m_cnt [N], m_snap [N];
  bit m_ovf [N];
  int m_cyc, m_ph, e_live, e_snap, e_live2, e_snap2;
  bit m_counting, e_sv;
  int checks = 0, errors = 0;

  perf_counter_bank #(.NUM_CH(N), .CNT_W(W), .SNAP_INTERVAL(SI)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_freeze(fr), .i_clear(clr),
    .i_event(ev), .i_rd_sel(sel), .o_rd_live(live), .o_rd_snap(snap),
    .o_cycle_count(cyc), .o_snap_valid(sv), .o_overflow(ovf));

  perf_counter_bank #(.NUM_CH(N2), .CNT_W(W), .SNAP_INTERVAL(SI)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_freeze(fr), .i_clear(clr),
    .i_event(ev[N2-1:0]), .i_rd_sel(sel2), .o_rd_live(live2), .o_rd_snap(snap2),
    .o_cycle_count(cyc2), .o_snap_valid(sv2), .o_overflow(ovf2));

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = 0; m_snap[i] = 0; m_ovf[i] = 1'b0;
    end
    m_cyc = 0; m_ph = 0; m_counting = 1'b0;
    e_live = 0; e_snap = 0; e_live2 = 0; e_snap2 = 0; e_sv = 1'b0;
  endfunction

  // one clock edge of the specified behaviour: reads see old values, then counts update
  function automatic void model_edge();
    e_live  = m_cnt[sel];
    e_snap  = m_snap[sel];
    e_live2 = (sel2 < N2) ? m_cnt[sel2] : 0;
    e_snap2 = (sel2 < N2) ? m_snap[sel2] : 0;
    e_sv = 1'b0;
    if (clr) begin
      for (int i = 0; i < N; i++) begin
        m_cnt[i] = 0; m_ovf[i] = 1'b0;
      end
      m_cyc = 0; m_ph = 0;
    end else if (m_counting) begin
      m_cyc = (m_cyc + 1) % (MAXV + 1);
      for (int i = 0; i < N; i++)
        if (ev[i]) begin
          if (m_cnt[i] == MAXV) begin
            m_ovf[i] = 1'b1;
            m_cnt[i] = SAT ? MAXV : 0;
          end else m_cnt[i]++;
        end
      m_ph++;
      if (m_ph == SI) begin
        m_ph = 0; m_snap = m_cnt; e_sv = 1'b1;
      end
    end
    m_counting = en && !fr;
  endfunction

  task automatic compare_all();
    logic [N-1:0] eo;
    for (int i = 0; i < N; i++) eo[i] = m_ovf[i];
    chk("rd_live", live, e_live);
    chk("rd_snap", snap, e_snap);
    chk("cycle_count", cyc, m_cyc);
    chk("snap_valid", sv, e_sv);
    chk("overflow", ovf, eo);
    chk("rd_live2", live2, e_live2);
    chk("rd_snap2", snap2, e_snap2);
    chk("cycle_count2", cyc2, m_cyc);
    chk("snap_valid2", sv2, e_sv);
    chk("overflow2", ovf2, eo[N2-1:0]);
  endtask

  task automatic step(input bit e, input bit f, input bit c, input logic [N-1:0] v,
                      input logic [1:0] s, input logic [1:0] s2);
    en = e; fr = f; clr = c; ev = v; sel = s; sel2 = s2;
    @(posedge clk);
    model_edge();
    #1 compare_all();
  endtask

  initial begin
    m_reset();
    #12;
    chk("reset_live", live, 0); chk("reset_snap", snap, 0); chk("reset_cyc", cyc, 0);
    chk("reset_sv", sv, 0); chk("reset_ovf", ovf, 0);
    @(negedge clk) rst_n = 1'b1;
    step(1, 0, 0, '0, 0, 0);
    repeat (10) step(1, 0, 0, 4'b0101, 0, 0);
    chk("snap_valid_cycle11", sv, 1);
    chk("cyc_after_10", cyc, 10);
    step(0, 0, 0, '0, 0, 0);
    chk("snap_ch0", snap, 10);
    chk("snap_valid_one_cycle", sv, 0);
    step(0, 0, 0, '0, 1, 1);
    chk("snap_ch1", snap, 0);
    step(0, 0, 0, '0, 2, 2);
    chk("snap_ch2", snap, 10);
    chk("snap2_ch2", snap2, 10);
    step(0, 0, 0, '0, 0, 3);
    chk("oor_live", live2, 0);
    chk("oor_snap", snap2, 0);
    step(1, 0, 0, '0, 0, 0);
    repeat (5) step(1, 1, 0, 4'b1111, 0, 0);
    step(1, 0, 0, 4'b1111, 0, 0);
    chk("freeze_cyc_held", cyc, 12);
    step(1, 0, 0, 4'b1111, 0, 0);
    chk("freeze_resume", cyc, 13);
    step(1, 0, 1, '0, 3, 0);
    repeat (255) step(1, 0, 0, 4'b1000, 3, 0);
    chk("ovf3_before", ovf[3], 0);
    step(1, 0, 0, 4'b1000, 3, 0);
    step(1, 0, 0, '0, 3, 0);
    chk("ovf3_live", live, SAT ? 255 : 0);
    chk("ovf3_flag", ovf[3], 1);
    step(1, 0, 1, '0, 0, 0);
    repeat (9) step(1, 0, 0, N'($urandom), 0, 0);
    step(1, 0, 1, 4'b1111, 0, 0);
    chk("clear_no_sv", sv, 0);
    chk("clear_cyc", cyc, 0);
    chk("clear_ovf", ovf, 0);
    step(1, 0, 0, '0, 0, 0);
    step(1, 0, 1, '0, 0, 0);
    repeat (6) step(1, 0, 0, N'($urandom), 1, 1);
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    chk("async_live", live, 0); chk("async_cyc", cyc, 0); chk("async_ovf", ovf, 0);
    chk("async_snap", snap, 0); chk("async_sv", sv, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (10) step(1, 0, 0, N'($urandom), 0, 0);
    chk("post_reset_no_sv", sv, 0);
    step(1, 0, 0, N'($urandom), 0, 0);
    chk("post_reset_sv", sv, 1);
    repeat (800)
      step($urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0,
           N'($urandom), 2'($urandom), 2'($urandom));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
